ysyx_20020207_lsu: RTL and testbench

YSYX_20020207_LSU -- requirements
Module: ysyx_20020207_LSU

---
 rtl/ysyx_20020207_lsu_if.sv | 43 ++++
 rtl/ysyx_20020207_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_20020207_lsu.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_20020207_lsu_if.sv
// rtl/ysyx_20020207_lsu_if.sv - pipeline and memory-bus signal bundle for the LSU
interface ysyx_20020207_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic        access_fault;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  in_valid, alu_result, store_data, mem_op, funct3, rd_in,
    output in_ready,
    output out_valid, wb_data, rd_out, access_fault,
    input  out_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    output in_valid, alu_result, store_data, mem_op, funct3, rd_in,
    input  in_ready,
    input  out_valid, wb_data, rd_out, access_fault,
    output out_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_20020207_lsu.sv
// rtl/ysyx_20020207_lsu.sv - load/store unit: IDLE/REQ/RESP/DONE FSM with lane steering,
// alignment faults and a bounded response wait.
module ysyx_20020207_lsu #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_20020207_lsu_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        fault_q, fault_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic        in_fault;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;

  // Fault decode on the incoming request; pass-through never faults.
  always_comb begin
    in_fault = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: in_fault = 1'b0;
      3'b001, 3'b101: in_fault = bus.alu_result[0];
      3'b010:         in_fault = (bus.alu_result[1:0] != 2'b00);
      default:        in_fault = 1'b1;
    endcase
    if (bus.mem_op == 2'b10 && bus.funct3[2]) in_fault = 1'b1;
    if (bus.mem_op == 2'b11) in_fault = 1'b1;
  end

  always_comb begin
    st_wdata = bus.store_data;
    st_wmask = 4'b1111;
    case (bus.funct3[1:0])
      2'b00: begin
        st_wdata = {4{bus.store_data[7:0]}};
        st_wmask = 4'b0001 << bus.alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{bus.store_data[15:0]}};
        st_wmask = 4'b0011 << bus.alu_result[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = bus.mem_rdata >> {addr_lo_q, 3'b000};
    load_val = bus.mem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wb_data_d   = wb_data_q;
    rd_out_d    = rd_out_q;
    fault_d     = fault_q;
    req_valid_d = req_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d      = bus.mem_op;
          f3_d      = bus.funct3;
          addr_lo_d = bus.alu_result[1:0];
          rd_out_d  = bus.rd_in;
          if (bus.mem_op == 2'b00) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            wb_data_d   = bus.alu_result;
            fault_d     = 1'b0;
          end else if (in_fault) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            wb_data_d   = 32'd0;
            fault_d     = 1'b1;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            mem_addr_d  = {bus.alu_result[31:2], 2'b00};
            mem_wen_d   = (bus.mem_op == 2'b10);
            mem_wdata_d = (bus.mem_op == 2'b10) ? st_wdata : 32'd0;
            mem_wmask_d = (bus.mem_op == 2'b10) ? st_wmask : 4'b0000;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d     = RESP;
          req_valid_d = 1'b0;
          cnt_d       = 8'd0;
        end
      end
      RESP: begin
        if (bus.mem_resp_valid) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          wb_data_d   = (op_q == 2'b10) ? 32'd0 : load_val;
          fault_d     = 1'b0;
        end else if (cnt_q == LIMIT_M1) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          wb_data_d   = 32'd0;
          fault_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // in_ready is registered, so it mirrors the state being entered.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wb_data_q   <= 32'd0;
      rd_out_q    <= 5'd0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
      cnt_q       <= 8'd0;
      op_q        <= 2'd0;
      f3_q        <= 3'd0;
      addr_lo_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wb_data_q   <= wb_data_d;
      rd_out_q    <= rd_out_d;
      fault_q     <= fault_d;
      req_valid_q <= req_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.rd_out        = rd_out_q;
  assign bus.access_fault  = fault_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// tb/tb_ysyx_20020207_lsu.sv - directed self-checking bench for the LSU
module tb_ysyx_20020207_lsu;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  ysyx_20020207_lsu_if bus ();

  ysyx_20020207_lsu #(.WAIT_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.mem_op     = op;
    bus.funct3     = f3;
    bus.alu_result = a;
    bus.store_data = d;
    bus.rd_in      = rd;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  // Runs one memory access with zero stall and an immediate response; returns observations.
  task automatic mem_txn(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata,
                         output logic [31:0] p_addr, output logic p_wen,
                         output logic [31:0] p_wdata, output logic [3:0] p_wmask,
                         output logic p_ov, output logic [31:0] p_wb, output logic p_fault);
    accept(op, f3, a, d, 5'd3);
    p_addr  = bus.mem_addr;
    p_wen   = bus.mem_wen;
    p_wdata = bus.mem_wdata;
    p_wmask = bus.mem_wmask;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = rdata;
    tick();
    bus.mem_resp_valid = 1'b0;
    p_ov    = bus.out_valid;
    p_wb    = bus.wb_data;
    p_fault = bus.access_fault;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
    tests++; if (bus.wb_data !== 32'd0 || bus.rd_out !== 5'd0 || bus.access_fault !== 1'b0) begin
      fails++; $display("FAIL rst_payload: wb=%h rd=%0d fault=%b want 0/0/0", bus.wb_data, bus.rd_out, bus.access_fault);
    end
    reset = 1'b0;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_pass_through();
    bus.out_ready = 1'b1;
    accept(2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL pt_out_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.wb_data !== 32'h1234_5678 || bus.rd_out !== 5'd5) begin
      fails++; $display("FAIL pt_payload: wb=%h rd=%0d want 12345678/5", bus.wb_data, bus.rd_out);
    end
    tests++; if (bus.mem_req_valid !== 1'b0 || bus.access_fault !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL pt_side: req=%b fault=%b in_ready=%b want 0/0/0", bus.mem_req_valid, bus.access_fault, bus.in_ready);
    end
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL pt_return: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] p_addr, p_wdata, p_wb;
    logic [3:0]  p_wmask;
    logic        p_wen, p_ov, p_fault;
    logic [2:0]  f3_t  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] a_t   [6] = '{32'h1003, 32'h1003, 32'h6002, 32'h6002, 32'h7000, 32'h1001};
    logic [31:0] rd_t  [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000, 32'hCAFE_F00D, 32'h0000_7F00};
    logic [31:0] ex_a  [6] = '{32'h1000, 32'h1000, 32'h6000, 32'h6000, 32'h7000, 32'h1000};
    logic [31:0] ex_wb [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hCAFE_F00D, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      mem_txn(2'b01, f3_t[i], a_t[i], 32'hFFFF_FFFF, rd_t[i], p_addr, p_wen, p_wdata, p_wmask, p_ov, p_wb, p_fault);
      tests++; if (p_addr !== ex_a[i] || p_wen !== 1'b0 || p_wmask !== 4'b0000) begin
        fails++; $display("FAIL load%0d_req: addr=%h wen=%b mask=%b want %h/0/0000", i, p_addr, p_wen, p_wmask, ex_a[i]);
      end
      tests++; if (p_ov !== 1'b1 || p_wb !== ex_wb[i] || p_fault !== 1'b0) begin
        fails++; $display("FAIL load%0d_wb: ov=%b wb=%h fault=%b want 1/%h/0", i, p_ov, p_wb, p_fault, ex_wb[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] p_addr, p_wdata, p_wb;
    logic [3:0]  p_wmask;
    logic        p_wen, p_ov, p_fault;
    mem_txn(2'b10, 3'b000, 32'h5001, 32'h1234_5678, 32'hDEAD_BEEF, p_addr, p_wen, p_wdata, p_wmask, p_ov, p_wb, p_fault);
    tests++; if (p_addr !== 32'h5000 || p_wen !== 1'b1 || p_wdata !== 32'h7878_7878 || p_wmask !== 4'b0010) begin
      fails++; $display("FAIL sb_req: addr=%h wen=%b wdata=%h mask=%b want 5000/1/78787878/0010", p_addr, p_wen, p_wdata, p_wmask);
    end
    tests++; if (p_ov !== 1'b1 || p_wb !== 32'd0 || p_fault !== 1'b0) begin
      fails++; $display("FAIL sb_wb: ov=%b wb=%h fault=%b want 1/0/0", p_ov, p_wb, p_fault);
    end
    mem_txn(2'b10, 3'b010, 32'h5004, 32'hA5A5_0F0F, 32'hDEAD_BEEF, p_addr, p_wen, p_wdata, p_wmask, p_ov, p_wb, p_fault);
    tests++; if (p_addr !== 32'h5004 || p_wen !== 1'b1 || p_wdata !== 32'hA5A5_0F0F || p_wmask !== 4'b1111) begin
      fails++; $display("FAIL sw_req: addr=%h wen=%b wdata=%h mask=%b want 5004/1/a5a50f0f/1111", p_addr, p_wen, p_wdata, p_wmask);
    end
  endtask

  task automatic test_sh_stall();
    accept(2'b10, 3'b001, 32'h2002, 32'hAAAA_BEEF, 5'd4);
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_wen !== 1'b1 ||
                   bus.mem_wdata !== 32'hBEEF_BEEF || bus.mem_wmask !== 4'b1100) begin
        fails++; $display("FAIL sh_stall%0d: v=%b addr=%h wen=%b wdata=%h mask=%b want 1/2000/1/beefbeef/1100",
                          i, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      tick();
    end
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tests++; if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL sh_early_resp: req=%b out_valid=%b want 0/0", bus.mem_req_valid, bus.out_valid);
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== 32'd0 || bus.access_fault !== 1'b0 || bus.rd_out !== 5'd4) begin
      fails++; $display("FAIL sh_done: ov=%b wb=%h fault=%b rd=%0d want 1/0/0/4", bus.out_valid, bus.wb_data, bus.access_fault, bus.rd_out);
    end
    tick();
  endtask

  task automatic test_faults();
    logic [1:0]  op_t [5] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b01};
    logic [2:0]  f3_t [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b011};
    logic [31:0] a_t  [5] = '{32'h3001, 32'h3000, 32'h3000, 32'h3003, 32'h3000};
    for (int i = 0; i < 5; i++) begin
      accept(op_t[i], f3_t[i], a_t[i], 32'h1111_2222, 5'd6);
      tests++; if (bus.out_valid !== 1'b1 || bus.access_fault !== 1'b1 || bus.wb_data !== 32'd0 || bus.mem_req_valid !== 1'b0) begin
        fails++; $display("FAIL fault%0d: ov=%b fault=%b wb=%h req=%b want 1/1/0/0", i, bus.out_valid, bus.access_fault, bus.wb_data, bus.mem_req_valid);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    accept(2'b10, 3'b010, 32'h4000, 32'h1111_1111, 5'd9);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL timeout_early%0d: out_valid=%b want 0", i, bus.out_valid); end
    end
    tick();
    tests++; if (bus.out_valid !== 1'b1 || bus.access_fault !== 1'b1 || bus.wb_data !== 32'd0) begin
      fails++; $display("FAIL timeout_done: ov=%b fault=%b wb=%h want 1/1/0", bus.out_valid, bus.access_fault, bus.wb_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    accept(2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 5'd12);
    bus.mem_op     = 2'b00;
    bus.alu_result = 32'h0000_0BAD;
    bus.rd_in      = 5'd13;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== 32'hCAFE_0001 || bus.rd_out !== 5'd12 || bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL hold%0d: ov=%b wb=%h rd=%0d in_ready=%b want 1/cafe0001/12/0", i, bus.out_valid, bus.wb_data, bus.rd_out, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL release: ov=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== 32'h0000_0BAD || bus.rd_out !== 5'd13) begin
      fails++; $display("FAIL next_accept: ov=%b wb=%h rd=%0d want 1/00000bad/13", bus.out_valid, bus.wb_data, bus.rd_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    accept(2'b01, 3'b010, 32'h1000, 32'h0, 5'd2);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset: ov=%b in_ready=%b req=%b want 0/0/0", bus.out_valid, bus.in_ready, bus.mem_req_valid);
    end
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h5555_AAAA;
    tick();
    bus.mem_resp_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL late_resp: ov=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL late_resp2: ov=%b want 0", bus.out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid       = 1'b0;
    bus.alu_result     = 32'd0;
    bus.store_data     = 32'd0;
    bus.mem_op         = 2'b00;
    bus.funct3         = 3'b000;
    bus.rd_in          = 5'd0;
    bus.out_ready      = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'd0;
    test_reset();
    test_pass_through();
    test_loads();
    test_stores();
    test_sh_stall();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
